dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU memory stage and the 128-bit-line data memory. It accepts single-word CPU loads and stores and answers hits from its internal line array. On a miss it acts as the initiator of the memory request/response protocol: it writes back a dirty victim if needed, fetches the line, then replays the access.

## Interface
Parameters:
- NUM_LINES, 4: number of cache lines; power of two, at least 2. INDEX_W = log2(NUM_LINES).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- cpu_req  input  cpu_req_type  {valid, rw (1 = write), addr[31:0], data[31:0]}.
- cpu_res  output  cpu_res_type  {data[31:0], ready}.
- mem_req  output  mem_req_type  {valid, rw, addr[31:0], data[127:0]}.
- mem_data  input  mem_data_type  {data[127:0], ready}.
- hit_count  output  32  saturating count of accesses that hit on first COMPARE.
- miss_count  output  32  saturating count of accesses that missed.

## Operation
- Address split:
  - word offset = addr[3:2];
  - index = addr[4+INDEX_W-1:4];
  - tag = addr[31:4+INDEX_W];
  - addr[1:0] ignored.
- Per line: valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits. Tag and data arrays are not reset.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
  - IDLE: if cpu_req.valid, go to COMPARE.
  - COMPARE, hit (valid && tag match):
    - assert cpu_res.ready;
    - on a read, drive cpu_res.data with the selected word;
    - on a write, update that word and set dirty;
    - go to IDLE.
  - COMPARE, miss: if the victim is valid and dirty, go to WRITE_BACK; otherwise go to ALLOCATE.
  - WRITE_BACK: mem_req = {valid 1, rw 1, addr {victim tag, index, 4'b0}, data victim line}. On mem_data.ready, go to ALLOCATE.
  - ALLOCATE: mem_req = {valid 1, rw 0, addr {req tag, index, 4'b0}}. On mem_data.ready:
    - load the line and tag;
    - set valid = 1, dirty = 0;
    - go to COMPARE (the replay always hits).
- Outputs are combinational from state. Defaults when inactive:
  - cpu_res.data = 0, cpu_res.ready = 0;
  - mem_req.valid = 0, mem_req.rw = 0, mem_req.addr = 0, mem_req.data = 0.
  - cpu_res.data is 0 on a write hit.
- Counters:
  - hit_count increments only on a COMPARE hit that is not a replay;
  - miss_count increments on each COMPARE miss;
  - both saturate at 0xFFFF_FFFF and reset to 0.

## Timing
- Cycle 0 is the first cycle in which cpu_req.valid is high while in IDLE. The CPU holds cpu_req stable until cpu_res.ready.
- L is the memory latency: cycles from the first mem_req.valid cycle up to and including the ready cycle. The data memory has L = 7.
- Hit: ready in cycle 1.
- Clean miss:
  - ALLOCATE occupies cycles 2..L+1;
  - ready in cycle L+2 (9 for L = 7).
- Dirty miss:
  - WRITE_BACK occupies cycles 2..L+1;
  - ALLOCATE occupies cycles L+2..2L+1;
  - ready in cycle 2L+2 (16).
- mem_req is held stable from its first valid cycle through the ready cycle.
- The WRITE_BACK to ALLOCATE transition presents a new request in the next cycle (back-to-back). The memory treats it as a fresh request.
- mem_data.ready seen outside WRITE_BACK or ALLOCATE is ignored.
- cpu_req.valid dropping mid-miss is illegal (behaviour undefined).
- Reset mid-operation:
  - state returns to IDLE immediately (asynchronous);
  - mem_req.valid and cpu_res.ready go to 0;
  - the in-flight line is discarded and all lines become invalid.

## Structure
- Shared package additions: cpu_req_type, cpu_res_type, and the state enum dcache_state_t. mem_req_type, mem_data_type and cache_data_type are reused unchanged.
- Sub-module dcache_line_array holds the storage:
  - tag, valid, dirty and data arrays;
  - asynchronous read by index;
  - synchronous line write and word write;
  - asynchronous clear of valid and dirty.
- The controller FSM and counters live in dcache_ctrl.

## Test plan
Bench uses NUM_LINES = 4 and a memory model with L = 7.
- Read miss: after reset, read 0x0000_0010, with memory line 0x10 = {W3, W2, W1, W0} = {4, 3, 2, 1}.
  - mem_req {rw 0, addr 0x10} is held in cycles 2..8;
  - cpu_res.ready in cycle 9 with data 0x1;
  - miss_count = 1.
- Read hit: then read 0x14.
  - ready in cycle 1, data 0x2;
  - mem_req.valid stays 0;
  - hit_count = 1.
- Write hit: write 0x14 = 0xDEADBEEF.
  - ready in cycle 1;
  - a subsequent read of 0x14 returns 0xDEADBEEF.
- Dirty eviction: read 0x0000_0050 (same index, new tag).
  - write-back at addr 0x10 with data {4, 3, 0xDEADBEEF, 1} in cycles 2..8;
  - allocate at addr 0x50 in cycles 9..15;
  - ready in cycle 16.
- Write miss (clean): write 0x24 = 0x55.
  - allocate at addr 0x20;
  - ready in cycle 9;
  - the line is then dirty, so a later read of 0x64 triggers a write-back to 0x20 containing 0x55 in word 1.
- Reset mid-ALLOCATE: pulse reset in cycle 5 of a miss.
  - mem_req.valid drops in that cycle;
  - counters read 0;
  - reading 0x14 again misses.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data cache controller and its memory-side protocol.
package dcache_ctrl_pkg;

   localparam int WORD_W = 32;
   localparam int LINE_W = 128;

   typedef logic [LINE_W-1:0] cache_data_type;

   typedef struct packed {
      logic                valid;
      logic                rw;
      logic [31:0]         addr;
      logic [WORD_W-1:0]   data;
   } cpu_req_type;

   typedef struct packed {
      logic [WORD_W-1:0]   data;
      logic                ready;
   } cpu_res_type;

   typedef struct packed {
      logic                valid;
      logic                rw;
      logic [31:0]         addr;
      cache_data_type      data;
   } mem_req_type;

   typedef struct packed {
      cache_data_type      data;
      logic                ready;
   } mem_data_type;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COMPARE    = 2'd1,
      WRITE_BACK = 2'd2,
      ALLOCATE   = 2'd3
   } dcache_state_t;

   // Pick one 32-bit word out of a 128-bit line.
   function automatic logic [WORD_W-1:0] word_sel(input cache_data_type line,
                                                  input logic [1:0] off);
      return line[{off, 5'b0} +: WORD_W];
   endfunction

endpackage

// File: rtl/dcache_ctrl_line_array.sv
// Tag/valid/dirty/data storage: async read by index, sync line or word write,
// async clear of the valid and dirty bits.
module dcache_ctrl_line_array
   import dcache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int INDEX_W   = $clog2(NUM_LINES),
   parameter int TAG_W     = 28 - INDEX_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  index_i,
   output logic                rd_valid_o,
   output logic                rd_dirty_o,
   output logic [TAG_W-1:0]    rd_tag_o,
   output cache_data_type      rd_data_o,
   input  logic                line_we_i,
   input  logic [TAG_W-1:0]    line_tag_i,
   input  cache_data_type      line_data_i,
   input  logic                word_we_i,
   input  logic [1:0]          word_off_i,
   input  logic [WORD_W-1:0]   word_data_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   cache_data_type       data_q [NUM_LINES];

   assign rd_valid_o = valid_q[index_i];
   assign rd_dirty_o = dirty_q[index_i];
   assign rd_tag_o   = tag_q[index_i];
   assign rd_data_o  = data_q[index_i];

   // Status bits: cleared on reset, fill makes a line clean, word write dirties it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_i) begin
         valid_q[index_i] <= 1'b1;
         dirty_q[index_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_q[index_i] <= 1'b1;
      end
   end

   // Tag and data payload; never reset, only meaningful while valid.
   always_ff @(posedge clock) begin
      if (line_we_i) begin
         tag_q[index_i]  <= line_tag_i;
         data_q[index_i] <= line_data_i;
      end else if (word_we_i) begin
         data_q[index_i][{word_off_i, 5'b0} +: WORD_W] <= word_data_i;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
//
// state      | meaning
// IDLE       | waiting for a CPU request
// COMPARE    | tag lookup; answer on hit, choose eviction path on miss
// WRITE_BACK | writing the dirty victim line to memory
// ALLOCATE   | fetching the requested line from memory
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  cpu_req_type   cpu_req,
   output cpu_res_type   cpu_res,
   output mem_req_type   mem_req,
   input  mem_data_type  mem_data,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
);

   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int TAG_W   = 28 - INDEX_W;

   dcache_state_t       state_q;
   logic                replay_q;
   logic [31:0]         hit_cnt_q;
   logic [31:0]         miss_cnt_q;

   logic [INDEX_W-1:0]  req_index;
   logic [TAG_W-1:0]    req_tag;
   logic [1:0]          req_off;
   logic                rd_valid;
   logic                rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   cache_data_type      rd_data;
   logic                hit;
   logic                line_we;
   logic                word_we;
   logic                unused_addr_lsb;

   assign req_off         = cpu_req.addr[3:2];
   assign req_index       = cpu_req.addr[4 +: INDEX_W];
   assign req_tag         = cpu_req.addr[31 -: TAG_W];
   assign unused_addr_lsb = ^cpu_req.addr[1:0];

   assign hit     = (state_q == COMPARE) && rd_valid && (rd_tag == req_tag);
   assign line_we = (state_q == ALLOCATE) && mem_data.ready;
   assign word_we = hit && cpu_req.rw;

   dcache_ctrl_line_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_W   (INDEX_W),
      .TAG_W     (TAG_W)
   ) u_lines (
      .clock       (clock),
      .reset       (reset),
      .index_i     (req_index),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_data_o   (rd_data),
      .line_we_i   (line_we),
      .line_tag_i  (req_tag),
      .line_data_i (mem_data.data),
      .word_we_i   (word_we),
      .word_off_i  (req_off),
      .word_data_i (cpu_req.data)
   );

   // Controller state, replay marker and saturating hit/miss counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         replay_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               replay_q <= 1'b0;
               if (cpu_req.valid) state_q <= COMPARE;
            end
            COMPARE: begin
               replay_q <= 1'b0;
               if (hit) begin
                  state_q <= IDLE;
                  if (!replay_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
               end else begin
                  if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                  state_q <= (rd_valid && rd_dirty) ? WRITE_BACK : ALLOCATE;
               end
            end
            WRITE_BACK: begin
               if (mem_data.ready) state_q <= ALLOCATE;
            end
            ALLOCATE: begin
               if (mem_data.ready) begin
                  state_q  <= COMPARE;
                  replay_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // CPU response and memory request decoded from the current state.
   always_comb begin
      cpu_res = '0;
      mem_req = '0;
      case (state_q)
         COMPARE: begin
            if (hit) begin
               cpu_res.ready = 1'b1;
               if (!cpu_req.rw) cpu_res.data = word_sel(rd_data, req_off);
            end
         end
         WRITE_BACK: begin
            mem_req.valid = 1'b1;
            mem_req.rw    = 1'b1;
            mem_req.addr  = {rd_tag, req_index, 4'b0};
            mem_req.data  = rd_data;
         end
         ALLOCATE: begin
            mem_req.valid = 1'b1;
            mem_req.addr  = {req_tag, req_index, 4'b0};
         end
         default: ;
      endcase
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency (L = 7) memory model.
module tb_dcache_ctrl;
   import dcache_ctrl_pkg::*;

   logic          clock;
   logic          reset;
   cpu_req_type   cpu_req;
   cpu_res_type   cpu_res;
   mem_req_type   mem_req;
   mem_data_type  mem_data;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;

   int total = 0;
   int bad   = 0;

   cache_data_type mem_q [0:15];
   int             lat_q;
   mem_req_type    log_q [0:40];
   int             cyc;
   logic [31:0]    rdata;

   dcache_ctrl #(.NUM_LINES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_res    (cpu_res),
      .mem_req    (mem_req),
      .mem_data   (mem_data),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: ready on the 7th consecutive valid cycle of a request.
   always_comb begin
      mem_data.ready = mem_req.valid && (lat_q == 6);
      mem_data.data  = mem_req.rw ? '0 : mem_q[mem_req.addr[7:4]];
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_q <= 0;
         for (int n = 0; n < 16; n++)
            for (int k = 0; k < 4; k++)
               mem_q[n][k*32 +: 32] <= 32'(4*n + k - 3);
      end else begin
         if (mem_req.valid && !mem_data.ready) lat_q <= lat_q + 1;
         else lat_q <= 0;
         if (mem_data.ready && mem_req.rw) mem_q[mem_req.addr[7:4]] <= mem_req.data;
      end
   end

   // One CPU access; logs mem_req per cycle and returns the ready cycle.
   task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         output int rcyc, output logic [31:0] rd);
      @(negedge clock);
      cpu_req.valid = 1'b1;
      cpu_req.rw    = rw;
      cpu_req.addr  = addr;
      cpu_req.data  = wdata;
      rcyc = 0;
      rd   = '0;
      for (int i = 0; i <= 40; i++) log_q[i] = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         log_q[i] = mem_req;
         if (cpu_res.ready) begin
            rcyc = i;
            rd   = cpu_res.data;
            break;
         end
      end
      if (rcyc == 0) begin
         total++; bad++;
         $display("FAIL timeout addr=%h: no cpu_res.ready within 40 cycles", addr);
      end
      @(posedge clock);
      #1 cpu_req.valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_req = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL reset_hit got=%0d exp=0", hit_count); end
      total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL reset_miss got=%0d exp=0", miss_count); end
      total++; if (mem_req.valid !== 1'b0) begin bad++; $display("FAIL reset_memvalid got=%b exp=0", mem_req.valid); end
      total++; if (cpu_res.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", cpu_res.ready); end
   endtask

   task automatic test_read_miss();
      access(1'b0, 32'h10, 32'h0, cyc, rdata);
      total++; if (cyc !== 9) begin bad++; $display("FAIL rmiss_cycle got=%0d exp=9", cyc); end
      total++; if (rdata !== 32'h1) begin bad++; $display("FAIL rmiss_data got=%h exp=1", rdata); end
      total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL rmiss_count got=%0d exp=1", miss_count); end
      total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rmiss_hitcnt got=%0d exp=0", hit_count); end
      total++; if (log_q[1].valid !== 1'b0) begin bad++; $display("FAIL rmiss_c1 got=%b exp=0", log_q[1].valid); end
      for (int c = 2; c <= 8; c++) begin
         total++;
         if (log_q[c].valid !== 1'b1 || log_q[c].rw !== 1'b0 || log_q[c].addr !== 32'h10) begin
            bad++; $display("FAIL rmiss_req c=%0d got v=%b rw=%b a=%h exp v=1 rw=0 a=10",
                            c, log_q[c].valid, log_q[c].rw, log_q[c].addr);
         end
      end
   endtask

   task automatic test_read_hit();
      access(1'b0, 32'h14, 32'h0, cyc, rdata);
      total++; if (cyc !== 1) begin bad++; $display("FAIL rhit_cycle got=%0d exp=1", cyc); end
      total++; if (rdata !== 32'h2) begin bad++; $display("FAIL rhit_data got=%h exp=2", rdata); end
      total++; if (log_q[1].valid !== 1'b0) begin bad++; $display("FAIL rhit_memvalid got=%b exp=0", log_q[1].valid); end
      total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL rhit_count got=%0d exp=1", hit_count); end
   endtask

   task automatic test_write_hit();
      access(1'b1, 32'h14, 32'hDEADBEEF, cyc, rdata);
      total++; if (cyc !== 1) begin bad++; $display("FAIL whit_cycle got=%0d exp=1", cyc); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL whit_data got=%h exp=0", rdata); end
      access(1'b0, 32'h14, 32'h0, cyc, rdata);
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL whit_readback got=%h exp=deadbeef", rdata); end
      total++; if (hit_count !== 32'd3) begin bad++; $display("FAIL whit_count got=%0d exp=3", hit_count); end
   endtask

   task automatic test_dirty_evict();
      access(1'b0, 32'h50, 32'h0, cyc, rdata);
      total++; if (cyc !== 16) begin bad++; $display("FAIL evict_cycle got=%0d exp=16", cyc); end
      total++; if (rdata !== 32'd17) begin bad++; $display("FAIL evict_data got=%h exp=11", rdata); end
      for (int c = 2; c <= 8; c++) begin
         total++;
         if (log_q[c].valid !== 1'b1 || log_q[c].rw !== 1'b1 || log_q[c].addr !== 32'h10 ||
             log_q[c].data !== {32'd4, 32'd3, 32'hDEADBEEF, 32'd1}) begin
            bad++; $display("FAIL evict_wb c=%0d got v=%b rw=%b a=%h d=%h exp v=1 rw=1 a=10 d=00000004_00000003_deadbeef_00000001",
                            c, log_q[c].valid, log_q[c].rw, log_q[c].addr, log_q[c].data);
         end
      end
      for (int c = 9; c <= 15; c++) begin
         total++;
         if (log_q[c].valid !== 1'b1 || log_q[c].rw !== 1'b0 || log_q[c].addr !== 32'h50) begin
            bad++; $display("FAIL evict_alloc c=%0d got v=%b rw=%b a=%h exp v=1 rw=0 a=50",
                            c, log_q[c].valid, log_q[c].rw, log_q[c].addr);
         end
      end
      total++; if (miss_count !== 32'd2) begin bad++; $display("FAIL evict_count got=%0d exp=2", miss_count); end
   endtask

   task automatic test_write_miss();
      access(1'b1, 32'h24, 32'h55, cyc, rdata);
      total++; if (cyc !== 9) begin bad++; $display("FAIL wmiss_cycle got=%0d exp=9", cyc); end
      total++;
      if (log_q[2].valid !== 1'b1 || log_q[2].rw !== 1'b0 || log_q[2].addr !== 32'h20) begin
         bad++; $display("FAIL wmiss_alloc got v=%b rw=%b a=%h exp v=1 rw=0 a=20",
                         log_q[2].valid, log_q[2].rw, log_q[2].addr);
      end
      access(1'b0, 32'h64, 32'h0, cyc, rdata);
      total++; if (cyc !== 16) begin bad++; $display("FAIL wmiss_evict_cycle got=%0d exp=16", cyc); end
      total++;
      if (log_q[5].rw !== 1'b1 || log_q[5].addr !== 32'h20 ||
          log_q[5].data !== {32'd8, 32'd7, 32'h55, 32'd5}) begin
         bad++; $display("FAIL wmiss_wb got rw=%b a=%h d=%h exp rw=1 a=20 d=00000008_00000007_00000055_00000005",
                         log_q[5].rw, log_q[5].addr, log_q[5].data);
      end
      total++; if (miss_count !== 32'd4) begin bad++; $display("FAIL wmiss_count got=%0d exp=4", miss_count); end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      cpu_req.valid = 1'b1;
      cpu_req.rw    = 1'b0;
      cpu_req.addr  = 32'h84;
      cpu_req.data  = '0;
      repeat (5) @(negedge clock);
      total++; if (mem_req.valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", mem_req.valid); end
      reset = 1'b1;
      cpu_req.valid = 1'b0;
      #1;
      total++; if (mem_req.valid !== 1'b0) begin bad++; $display("FAIL midrst_memvalid got=%b exp=0", mem_req.valid); end
      total++; if (cpu_res.ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", cpu_res.ready); end
      total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         bad++; $display("FAIL midrst_counts got hit=%0d miss=%0d exp 0 0", hit_count, miss_count);
      end
      @(negedge clock);
      reset = 1'b0;
      access(1'b0, 32'h14, 32'h0, cyc, rdata);
      total++; if (cyc !== 9) begin bad++; $display("FAIL midrst_remiss_cycle got=%0d exp=9", cyc); end
      total++; if (rdata !== 32'h2) begin bad++; $display("FAIL midrst_remiss_data got=%h exp=2", rdata); end
      total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL midrst_remiss_count got=%0d exp=1", miss_count); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_dirty_evict();
      test_write_miss();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
